mem_port_arbiter: RTL and testbench

Shares the single external memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage, driven by the EX/MEM register's mem_read/mem_write). It sequences one ack-terminated transaction at a time and generates the stall signals that freeze the pipeline registers until each request completes. Data requests have priority. A starvation counter guarantees forward progress for instruction fetch.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;

    logic d_pend;
    logic ack_i;
    logic ack_d;
    logic starve_ok;

    assign d_pend    = d_read | d_write;
    assign ack_i     = (state_q == ST_BUSY_I) & mem_ack;
    assign ack_d     = (state_q == ST_BUSY_D) & mem_ack;
    assign starve_ok = starve_cnt_q < CNT_W'(STARVE_MAX);

    // Arbitration, transaction launch and completion
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!i_req) begin
                    starve_cnt_d = '0;
                end
                if (d_pend && (!i_req || starve_ok)) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_req && starve_ok) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end else if (i_req) begin
                    state_d      = ST_BUSY_I;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_addr;
                    mem_wdata_d  = d_wdata;
                    starve_cnt_d = '0;
                end
            end
            ST_BUSY_I: begin
                if (mem_ack) begin
                    i_rdata_d = mem_rdata;
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            ST_BUSY_D: begin
                if (mem_ack) begin
                    d_rdata_d = mem_rdata;
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Stall drops and read data is forwarded in the ack cycle itself
    assign i_stall   = i_req  & ~ack_i;
    assign d_stall   = d_pend & ~ack_d;
    assign i_rdata   = ack_i ? mem_rdata : i_rdata_q;
    assign d_rdata   = ack_d ? mem_rdata : d_rdata_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus a starvation sequence
// driven by a simple one-cycle-ack memory responder.
module tb_mem_port_arbiter;

    localparam logic [31:0] IA = 32'h0000_0040;
    localparam logic [31:0] DA = 32'h0000_0100;
    localparam logic [31:0] WD = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_port_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        i_req;
        logic        d_read;
        logic        d_write;
        logic        ack;
        logic [31:0] rdata;
        logic        e_istall;
        logic        e_dstall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic r, input logic ir, input logic dr, input logic dw,
                       input logic ak, input logic [31:0] rd,
                       input logic eis, input logic eds, input logic erq, input logic ewe,
                       input logic [31:0] ea, input logic [31:0] ewd,
                       input logic [31:0] eird, input logic [31:0] edrd);
        vec_t v;
        v.rst = r; v.i_req = ir; v.d_read = dr; v.d_write = dw; v.ack = ak; v.rdata = rd;
        v.e_istall = eis; v.e_dstall = eds; v.e_req = erq; v.e_we = ewe;
        v.e_addr = ea; v.e_wdata = ewd; v.e_ird = eird; v.e_drd = edrd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        logic [31:0] pa;
        logic [31:0] pd;
        logic        grants[$];
        logic        exp_g[6];
        int          cyc;

        rst = 1'b1; i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = IA; d_addr = DA; d_wdata = WD; mem_ack = 1'b0; mem_rdata = '0;

        // Isolated fetch, ack on third mem_req cycle
        add(0,0,0,0,0,0,            0,0,0,0, 0 ,0 ,0,0);
        add(0,1,0,0,0,0,            1,0,0,0, 0 ,0 ,0,0);
        add(0,1,0,0,0,0,            1,0,1,0, IA,WD,0,0);
        add(0,1,0,0,0,0,            1,0,1,0, IA,WD,0,0);
        add(0,1,0,0,1,32'hDEADBEEF, 0,0,1,0, IA,WD,32'hDEADBEEF,0);
        add(0,0,0,0,0,0,            0,0,0,0, IA,WD,32'hDEADBEEF,0);
        // Data write
        add(0,0,0,1,0,0,            0,1,0,0, IA,WD,32'hDEADBEEF,0);
        add(0,0,0,1,0,0,            0,1,1,1, DA,WD,32'hDEADBEEF,0);
        add(0,0,0,1,1,32'hAAAA5555, 0,0,1,1, DA,WD,32'hDEADBEEF,32'hAAAA5555);
        add(0,0,0,0,0,0,            0,0,0,0, DA,WD,32'hDEADBEEF,32'hAAAA5555);
        // Contention: data first, fetch after one IDLE cycle
        add(0,1,1,0,0,0,            1,1,0,0, DA,WD,32'hDEADBEEF,32'hAAAA5555);
        add(0,1,1,0,1,32'h11111111, 1,0,1,0, DA,WD,32'hDEADBEEF,32'h11111111);
        add(0,1,0,0,0,0,            1,0,0,0, DA,WD,32'hDEADBEEF,32'h11111111);
        add(0,1,0,0,1,32'h22222222, 0,0,1,0, IA,WD,32'h22222222,32'h11111111);
        add(0,0,0,0,0,0,            0,0,0,0, IA,WD,32'h22222222,32'h11111111);
        // Starvation: four data grants, then fetch, then data again
        for (int k = 1; k <= 4; k++) begin
            pa = (k == 1) ? IA : DA;
            pd = (k == 1) ? 32'h11111111 : (32'hD0000000 + 32'(k - 1));
            add(0,1,1,0,0,0,                   1,1,0,0, pa,WD,32'h22222222,pd);
            add(0,1,1,0,1,32'hD0000000+32'(k), 1,0,1,0, DA,WD,32'h22222222,32'hD0000000+32'(k));
        end
        add(0,1,1,0,0,0,            1,1,0,0, DA,WD,32'h22222222,32'hD0000004);
        add(0,1,1,0,1,32'h33333333, 0,1,1,0, IA,WD,32'h33333333,32'hD0000004);
        add(0,1,1,0,0,0,            1,1,0,0, IA,WD,32'h33333333,32'hD0000004);
        add(0,1,1,0,1,32'h44444444, 1,0,1,0, DA,WD,32'h33333333,32'h44444444);
        add(0,0,0,0,0,0,            0,0,0,0, DA,WD,32'h33333333,32'h44444444);
        // Read and write together act as a write
        add(0,0,1,1,0,0,            0,1,0,0, DA,WD,32'h33333333,32'h44444444);
        add(0,0,1,1,0,0,            0,1,1,1, DA,WD,32'h33333333,32'h44444444);
        add(0,0,1,1,1,32'h66666666, 0,0,1,1, DA,WD,32'h33333333,32'h66666666);
        add(0,0,0,0,0,0,            0,0,0,0, DA,WD,32'h33333333,32'h66666666);
        // Fetch withdrawn mid-transaction still runs to its ack
        add(0,1,0,0,0,0,            1,0,0,0, DA,WD,32'h33333333,32'h66666666);
        add(0,0,0,0,0,0,            0,0,1,0, IA,WD,32'h33333333,32'h66666666);
        add(0,0,0,0,1,32'h77777777, 0,0,1,0, IA,WD,32'h77777777,32'h66666666);
        add(0,0,0,0,0,0,            0,0,0,0, IA,WD,32'h77777777,32'h66666666);
        // Spurious ack in IDLE
        add(0,0,0,0,1,32'h55555555, 0,0,0,0, IA,WD,32'h77777777,32'h66666666);
        add(0,0,0,0,0,0,            0,0,0,0, IA,WD,32'h77777777,32'h66666666);
        // Reset in BUSY_D
        add(0,0,0,1,0,0,            0,1,0,0, IA,WD,32'h77777777,32'h66666666);
        add(1,0,0,1,0,0,            0,1,1,1, DA,WD,32'h77777777,32'h66666666);
        add(1,1,0,0,0,0,            1,0,0,0, 0 ,0 ,0,0);
        add(0,0,0,0,0,0,            0,0,0,0, 0 ,0 ,0,0);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst; i_req = vecs[i].i_req; d_read = vecs[i].d_read;
            d_write = vecs[i].d_write; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk("i_stall",   i, 32'(i_stall),  32'(vecs[i].e_istall));
            chk("d_stall",   i, 32'(d_stall),  32'(vecs[i].e_dstall));
            chk("mem_req",   i, 32'(mem_req),  32'(vecs[i].e_req));
            chk("mem_we",    i, 32'(mem_we),   32'(vecs[i].e_we));
            chk("mem_addr",  i, mem_addr,      vecs[i].e_addr);
            chk("mem_wdata", i, mem_wdata,     vecs[i].e_wdata);
            chk("i_rdata",   i, i_rdata,       vecs[i].e_ird);
            chk("d_rdata",   i, d_rdata,       vecs[i].e_drd);
        end

        // Both requesters saturated: grant order must be D,D,D,D,I,D (1 = data)
        exp_g[0] = 1'b1; exp_g[1] = 1'b1; exp_g[2] = 1'b1;
        exp_g[3] = 1'b1; exp_g[4] = 1'b0; exp_g[5] = 1'b1;
        cyc = 0;
        while (grants.size() < 6 && cyc < 100) begin
            @(posedge clk);
            #1;
            rst = 1'b0; i_req = 1'b1; d_read = 1'b1; d_write = 1'b0;
            mem_ack = mem_req;
            mem_rdata = 32'hC0DE0000 + 32'(cyc);
            @(negedge clk);
            if (mem_ack) begin
                grants.push_back(mem_addr == DA);
            end
            cyc++;
        end
        if (grants.size() < 6) begin
            tests++;
            fails++;
            $display("FAIL starve_seq timeout: got %0d grants expected 6", grants.size());
        end
        foreach (grants[g]) begin
            chk("starve_grant", g, 32'(grants[g]), 32'(exp_g[g]));
        end

        @(posedge clk);
        #1;
        i_req = 1'b0; d_read = 1'b0; mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
